atoi: RTL and testbench
=======================

# atoi

Parses a stream of ASCII decimal characters into a signed SIZE-bit two's-complement integer. Numbers are delimited by whitespace or line terminators, and each parsed value is emitted through a ready-valid output. The block is the receive-side counterpart of the integer-to-ASCII streamer: it sits between the UART RX byte stream and the numeric datapath.

## Interface
- SIZE, 64: width of the output integer in bits; must be at least 8.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- di  in  8  ASCII character
- diValid  in  1  di is valid
- diReady  out  1  block accepts di this cycle
- do  out  SIZE  parsed signed integer
- doValid  out  1  do, ovf are valid
- doReady  in  1  consumer accepts do this cycle
- ovf  out  1  qualifies do: value did not fit in SIZE-bit signed range, do is wrapped
- err  out  1  one-cycle pulse: malformed token dropped

## Operation
- Character classes:
  - digit: 0x30-0x39
  - minus: 0x2D
  - terminator: 0x0A (LF), 0x0D (CR), 0x20 (space)
  - anything else is invalid
- A token is an optional single leading minus followed by one or more digits, ended by a terminator.
- States:
  - Idle: no token in progress.
    - digit: acc<=digit, neg<=0, go to Digits.
    - minus: acc<=0, neg<=1, go to Sign.
    - terminator: ignored, so CRLF and repeated spaces produce nothing.
    - invalid: go to Discard.
  - Sign:
    - digit: acc<=digit, go to Digits.
    - minus, invalid: go to Discard.
    - terminator: pulse err, go to Idle.
  - Digits:
    - digit: acc<=acc*10+digit.
    - terminator: load do/ovf, go to Emit.
    - minus, invalid: go to Discard.
  - Discard: all characters are consumed. A terminator pulses err and returns to Idle.
  - Emit: doValid=1. On doReady, go to Idle.
- Accumulator arithmetic:
  - acc is an unsigned SIZE-bit magnitude.
  - acc*10 is formed as (acc<<3)+(acc<<1).
  - The result is kept modulo 2^SIZE.
  - ovfAcc is sticky within a token. It is set if any step's true result is ≥ 2^SIZE.
- Emit value: do = neg ? -acc : acc, truncated to SIZE bits.
- ovf = ovfAcc, OR acc > 2^(SIZE-1)-1 when positive, OR acc > 2^(SIZE-1) when negative.
  - Hence "-2^(SIZE-1)" parses exactly with ovf=0.
- Leading zeros are allowed. "-0" yields 0.
- '+' is invalid.

## Timing
- Reset values: do=0, doValid=0, ovf=0, err=0, state=Idle, acc=0, neg=0, ovfAcc=0. diReady=1 in the first cycle after reset.
- diReady is combinational: 1 in every state except Emit.
- A character is consumed in any cycle with diValid && diReady. The block processes one character per cycle with no bubbles.
- Latency: a terminator consumed in cycle N gives doValid=1 in cycle N+1.
- do and ovf hold stable while doValid && !doReady.
- doValid drops in the cycle after the handshake. The earliest next character is accepted in that same cycle.
- A terminator consumed in Emit is impossible, because diReady=0. Upstream stalls.
- err is high for exactly the cycle after the terminator that closes a malformed token. It is never asserted together with doValid for the same token.
- rst asserted mid-token or in Emit drops the partial or pending value. No output follows.

## Structure
- Shared header ascii.vh holds the constants ASCII_0, ASCII_9, ASCII_MINUS, ASCII_LF, ASCII_CR, ASCII_SP. The existing converter also uses them.
- State encodings are localparams inside the module.
- There is no sub-module. The ×10+digit step with carry-out detection is a single SIZE+4-bit combinational expression.

## Test plan
- "123\n" -> one output, do=123, ovf=0. No err.
- "-45\r\n" -> one output, do=-45 (0xFFFF_FFFF_FFFF_FFD3). The trailing LF produces nothing.
- "12a4 7\n" -> err pulse after the space, then one output do=7.
- "-\n" and "5-3\n" -> two err pulses, no outputs.
- Backpressure: "9 8 " with doReady held low for 5 cycles:
  - do=9 stays stable and diReady=0 throughout.
  - After the release, do=8 follows.
- SIZE=64 boundaries:
  - "-9223372036854775808\n" -> do=0x8000_0000_0000_0000, ovf=0.
  - "9223372036854775808\n" -> ovf=1.
  - "18446744073709551616\n" -> ovf=1, do=0.
  - rst asserted after "77" -> no output.

Source files
------------

// File: rtl/atoi_pkg.sv
// atoi_pkg: shared ASCII constants, FSM state type and character classifier
// for the ASCII-to-integer receive path.
package atoi_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SP    = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_SIGN, S_DIGITS, S_DISCARD, S_EMIT
  } state_t;

  typedef enum logic [1:0] {
    C_DIGIT, C_MINUS, C_TERM, C_BAD
  } cclass_t;

  function automatic cclass_t classify(logic [7:0] c);
    if (c >= ASCII_0 && c <= ASCII_9)                   return C_DIGIT;
    if (c == ASCII_MINUS)                               return C_MINUS;
    if (c == ASCII_LF || c == ASCII_CR || c == ASCII_SP) return C_TERM;
    return C_BAD;
  endfunction

endpackage

// File: rtl/atoi_if.sv
// atoi_if: character input stream plus parsed-integer output stream.
//   di/diValid/diReady : ASCII byte in (ready-valid)
//   dout/doValid/doReady/ovf : parsed signed value out (ready-valid), ovf qualifies dout
//   err : one-cycle pulse when a malformed token is dropped
// slave = the parser, master = the producer/consumer around it.
interface atoi_if #(parameter int SIZE = 64);
  logic [7:0]      di;
  logic            diValid;
  logic            diReady;
  logic [SIZE-1:0] dout;
  logic            doValid;
  logic            doReady;
  logic            ovf;
  logic            err;

  modport master (output di, diValid, doReady,
                  input  diReady, dout, doValid, ovf, err);
  modport slave  (input  di, diValid, doReady,
                  output diReady, dout, doValid, ovf, err);
endinterface

// File: rtl/atoi.sv
// atoi: parses whitespace/line-terminated ASCII decimal tokens ("-?[0-9]+")
// into signed SIZE-bit two's-complement values.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset; drops any partial or pending value
//   bus  : atoi_if.slave (di stream in, dout/ovf stream out, err pulse)
// dout is the parsed value (the name "do" is a reserved word).
module atoi
  import atoi_pkg::*;
#(
  parameter int SIZE = 64
) (
  input logic   clk,
  input logic   rst,
  atoi_if.slave bus
);

  state_t          state;
  logic [SIZE-1:0] acc;
  logic            neg;
  logic            ovf_acc;

  cclass_t         cls;
  logic            accept;
  logic [3:0]      dig;
  logic [SIZE+3:0] step;
  logic            step_c;
  logic            range_ovf;

  localparam logic [SIZE-1:0] HALF = {1'b1, {(SIZE-1){1'b0}}};

  assign cls         = classify(bus.di);
  assign bus.diReady = (state != S_EMIT);
  assign accept      = bus.diValid && bus.diReady;
  // low nibble of '0'..'9' is the digit value
  assign dig         = bus.di[3:0];

  // acc*10+digit with four extra bits so any carry past SIZE bits is visible
  assign step   = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (SIZE+4)'(dig);
  assign step_c = |step[SIZE+3:SIZE];

  // magnitude out of signed range: 2^(SIZE-1) is legal only when negative
  assign range_ovf = neg ? (acc > HALF) : acc[SIZE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      neg         <= 1'b0;
      ovf_acc     <= 1'b0;
      bus.dout    <= '0;
      bus.doValid <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.err <= 1'b0;
      unique case (state)
        S_IDLE: if (accept) begin
          unique case (cls)
            C_DIGIT: begin
              acc     <= SIZE'(dig);
              neg     <= 1'b0;
              ovf_acc <= 1'b0;
              state   <= S_DIGITS;
            end
            C_MINUS: begin
              acc     <= '0;
              neg     <= 1'b1;
              ovf_acc <= 1'b0;
              state   <= S_SIGN;
            end
            C_TERM:  ;
            C_BAD:   state <= S_DISCARD;
          endcase
        end
        S_SIGN: if (accept) begin
          unique case (cls)
            C_DIGIT: begin
              acc   <= SIZE'(dig);
              state <= S_DIGITS;
            end
            C_TERM: begin
              bus.err <= 1'b1;
              state   <= S_IDLE;
            end
            default: state <= S_DISCARD;
          endcase
        end
        S_DIGITS: if (accept) begin
          unique case (cls)
            C_DIGIT: begin
              acc     <= step[SIZE-1:0];
              ovf_acc <= ovf_acc | step_c;
            end
            C_TERM: begin
              bus.dout    <= neg ? -acc : acc;
              bus.ovf     <= ovf_acc | range_ovf;
              bus.doValid <= 1'b1;
              state       <= S_EMIT;
            end
            default: state <= S_DISCARD;
          endcase
        end
        S_DISCARD: if (accept && cls == C_TERM) begin
          bus.err <= 1'b1;
          state   <= S_IDLE;
        end
        S_EMIT: if (bus.doReady) begin
          bus.doValid <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atoi.sv
module tb_atoi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atoi_if #(.SIZE(64)) bus();
  atoi #(.SIZE(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct { bit is_err; logic [63:0] val; bit ovf; } ev_t;
  ev_t         q[$];
  byte         tok[$];
  logic [63:0] last_val = '0;
  bit          last_ovf = 1'b0;
  int          n_out = 0;
  int          n_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // model: tokens are maximal runs of non-terminators; a token is good if it
  // matches -?[0-9]+, and its value is checked against the signed 64-bit range
  function automatic void close_tok();
    ev_t e;
    bit ok = 1'b1;
    bit ng = 1'b0;
    int st = 0;
    logic [127:0] v = '0;
    logic [63:0]  lo;
    if (tok.size() == 0) return;
    if (tok[0] == 8'h2D) begin ng = 1'b1; st = 1; end
    if (tok.size() <= st) ok = 1'b0;
    for (int i = st; i < tok.size(); i++)
      if (tok[i] < 8'h30 || tok[i] > 8'h39) ok = 1'b0;
    e.is_err = !ok;
    e.val = '0;
    e.ovf = 1'b0;
    if (ok) begin
      for (int i = st; i < tok.size(); i++) v = v * 10 + 128'(tok[i] - 8'h30);
      lo = v[63:0];
      e.val = ng ? -lo : lo;
      e.ovf = ng ? (v > 128'h8000_0000_0000_0000) : (v > 128'h7FFF_FFFF_FFFF_FFFF);
    end
    q.push_back(e);
    tok.delete();
  endfunction

  function automatic void model_char(byte c);
    if (c == 8'h0A || c == 8'h0D || c == 8'h20) close_tok();
    else tok.push_back(c);
  endfunction

  task automatic send(string s, bit use_model);
    int n;
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      if (use_model) model_char(c);
      bus.di = c;
      bus.diValid = 1'b1;
      n = 0;
      while (!bus.diReady && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("send_timeout", 64'(n), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.diValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // compare process: every err pulse and every valid output cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.err) begin
        chk("err_expected", 64'(q.size() != 0 && q[0].is_err), 64'd1);
        chk("err_with_valid", 64'(bus.doValid), 64'd0);
        if (q.size() != 0 && q[0].is_err) begin
          void'(q.pop_front());
          n_err++;
        end
      end
      if (bus.doValid) begin
        if (q.size() == 0 || q[0].is_err) begin
          chk("unexpected_output", bus.dout, 64'hDEAD_0000_0000_0000);
          if (bus.doReady && q.size() != 0) void'(q.pop_front());
        end else begin
          chk("do", bus.dout, q[0].val);
          chk("ovf", 64'(bus.ovf), 64'(q[0].ovf));
          if (!bus.doReady) chk("diReady_hold", 64'(bus.diReady), 64'd0);
          else begin
            last_val = bus.dout;
            last_ovf = bus.ovf;
            n_out++;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.di = '0;
    bus.diValid = 1'b0;
    bus.doReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_do", bus.dout, 64'd0);
    chk("rst_doValid", 64'(bus.doValid), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;
    chk("rst_diReady", 64'(bus.diReady), 64'd1);

    send("123\n", 1); drain();
    chk("t123_val", last_val, 64'd123);
    chk("t123_ovf", 64'(last_ovf), 64'd0);
    chk("t123_nerr", 64'(n_err), 64'd0);

    send("-45\r\n", 1); drain();
    chk("tm45_val", last_val, 64'hFFFF_FFFF_FFFF_FFD3);
    chk("tm45_nout", 64'(n_out), 64'd2);

    send("12a4 7\n", 1); drain();
    chk("t7_val", last_val, 64'd7);
    chk("t7_nerr", 64'(n_err), 64'd1);

    send("-\n5-3\n", 1); drain();
    chk("terr_nerr", 64'(n_err), 64'd3);
    chk("terr_nout", 64'(n_out), 64'd3);

    send("-0 007 +5 ", 1); drain();
    chk("tzero_val", last_val, 64'd7);
    chk("tzero_nerr", 64'(n_err), 64'd4);

    // backpressure: hold 9 for 5 cycles, 8 must wait behind it
    bus.doReady = 1'b0;
    fork
      send("9 8 ", 1);
      begin
        n = 0;
        while (!bus.doValid && n < 100) begin @(negedge clk); n++; end
        repeat (5) begin
          chk("bp_do", bus.dout, 64'd9);
          chk("bp_diReady", 64'(bus.diReady), 64'd0);
          @(negedge clk);
        end
        bus.doReady = 1'b1;
      end
    join
    drain();
    chk("bp_last", last_val, 64'd8);

    send("-9223372036854775808\n", 1); drain();
    chk("min_val", last_val, 64'h8000_0000_0000_0000);
    chk("min_ovf", 64'(last_ovf), 64'd0);

    send("9223372036854775807\n", 1); drain();
    chk("max_val", last_val, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("max_ovf", 64'(last_ovf), 64'd0);

    send("9223372036854775808\n", 1); drain();
    chk("maxp1_ovf", 64'(last_ovf), 64'd1);

    send("18446744073709551616\n", 1); drain();
    chk("wrap_val", last_val, 64'd0);
    chk("wrap_ovf", 64'(last_ovf), 64'd1);

    // reset mid-token drops the partial value
    n = n_out;
    send("77", 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tok.delete();
    send("\n", 1);
    repeat (10) @(negedge clk);
    chk("rst_mid_nout", 64'(n_out), 64'(n));
    send("5\n", 1); drain();
    chk("post_rst_val", last_val, 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
